// File: rtl/clkdiv_cfg_sequencer.sv
// Sequences run-time DIV_N changes for the even clock divider: validate the ratio,
// wait for a period boundary, gate the divided clock, apply the ratio, settle, ungate.
module clkdiv_cfg_sequencer #(
    parameter logic [8:0]  DEFAULT_DIV_N = 9'd4,
    parameter int unsigned GATE_CYC      = 2,
    parameter int unsigned SETTLE_CYC    = 4,
    parameter int unsigned TIMEOUT_CYC   = 1023
) (
    input  logic       clk_in_pre,
    input  logic       rstn_out,
    input  logic       cfg_req,
    input  logic [8:0] cfg_div_n,
    output logic       cfg_ack,
    output logic       cfg_err,
    input  logic       div_period_end,
    output logic [8:0] div_n_o,
    output logic       clk_gate_en,
    output logic       busy,
    output logic       timeout_flag
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_END,
        GATE,
        APPLY,
        SETTLE,
        ACK
    } state_e;

    localparam logic [9:0] GATE_LAST    = 10'(GATE_CYC - 1);
    localparam logic [9:0] SETTLE_LAST  = 10'(SETTLE_CYC - 1);
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYC - 1);

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [8:0] shadow_q, shadow_d;
    logic [8:0] div_n_q, div_n_d;
    logic       gate_en_q, gate_en_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic ratioBad;
    logic ratioSame;
    logic waitExpired;

    assign ratioBad    = shadow_q[0] || (shadow_q < 9'd2);
    assign ratioSame   = (shadow_q == div_n_q);
    assign waitExpired = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            div_n_q   <= DEFAULT_DIV_N;
            gate_en_q <= 1'b1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            div_n_q   <= div_n_d;
            gate_en_q <= gate_en_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // The shared cycle counter restarts from zero whenever the state changes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (cfg_req) begin
                    shadow_d = cfg_div_n;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (ratioBad || ratioSame) state_d = ACK;
                else                       state_d = WAIT_END;
            end
            WAIT_END: begin
                if (div_period_end || waitExpired) state_d = GATE;
                else                               cnt_d   = cnt_q + 10'd1;
            end
            GATE: begin
                if (cnt_q == GATE_LAST) state_d = APPLY;
                else                    cnt_d   = cnt_q + 10'd1;
            end
            APPLY: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = ACK;
                else                      cnt_d   = cnt_q + 10'd1;
            end
            ACK: begin
                if (!cfg_req) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with it.
    always_comb begin
        div_n_d   = div_n_q;
        gate_en_d = 1'b1;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        busy_d    = (state_d != IDLE);
        timeout_d = timeout_q;
        if (state_d == APPLY) begin
            div_n_d = shadow_q;
        end
        if (state_d == GATE || state_d == APPLY || state_d == SETTLE) begin
            gate_en_d = 1'b0;
        end
        if (state_d == ACK) begin
            ack_d = 1'b1;
            err_d = (state_q == CHECK) ? ratioBad : err_q;
        end
        if (state_q == IDLE && cfg_req) begin
            timeout_d = 1'b0;
        end else if (state_q == WAIT_END && !div_period_end && waitExpired) begin
            timeout_d = 1'b1;
        end
    end

    assign cfg_ack      = ack_q;
    assign cfg_err      = err_q;
    assign div_n_o      = div_n_q;
    assign clk_gate_en  = gate_en_q;
    assign busy         = busy_q;
    assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_clkdiv_cfg_sequencer.sv
// Directed bench for clkdiv_cfg_sequencer: a cycle table for the basic handshakes,
// then hand sequences for timeout, mid-operation reset and a held request.
module tb_clkdiv_cfg_sequencer;

    logic       clk_in_pre = 1'b0;
    logic       rstn_out;
    logic       cfg_req;
    logic [8:0] cfg_div_n;
    logic       cfg_ack;
    logic       cfg_err;
    logic       div_period_end;
    logic [8:0] div_n_o;
    logic       clk_gate_en;
    logic       busy;
    logic       timeout_flag;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        logic       req;
        logic [8:0] divIn;
        logic       pe;
        logic       ack;
        logic       err;
        logic       gate;
        logic [8:0] divOut;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    clkdiv_cfg_sequencer dut (
        .clk_in_pre     (clk_in_pre),
        .rstn_out       (rstn_out),
        .cfg_req        (cfg_req),
        .cfg_div_n      (cfg_div_n),
        .cfg_ack        (cfg_ack),
        .cfg_err        (cfg_err),
        .div_period_end (div_period_end),
        .div_n_o        (div_n_o),
        .clk_gate_en    (clk_gate_en),
        .busy           (busy),
        .timeout_flag   (timeout_flag)
    );

    always #5 clk_in_pre = ~clk_in_pre;

    task automatic tick();
        @(posedge clk_in_pre);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic [8:0] divIn, input logic pe);
        cfg_req        = req;
        cfg_div_n      = divIn;
        div_period_end = pe;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        numChecks++;
        if (actual != expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitAck(input int maxCycles, output int cycles);
        cycles = 0;
        while (!cfg_ack && cycles < maxCycles) begin
            tick();
            cycles++;
        end
        checkOutput("ack_within_bound", int'(cfg_ack), 1);
    endtask

    int n;

    initial begin
        // Test 1: 4 -> 10 with period end three WAIT_END cycles in
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd4,  1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd4,  1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd4,  1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd4,  1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b1, 1'b0, 1'b0, 1'b0, 9'd4,  1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b0, 9'd4,  1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b0, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b0, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b0, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b0, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b0, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b1, 1'b0, 1'b1, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b1, 1'b0, 1'b1, 9'd10, 1'b1});
        vecs.push_back('{1'b0, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd10, 1'b0});
        vecs.push_back('{1'b0, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd10, 1'b0});
        // Test 2: odd and zero ratios are rejected without gating
        vecs.push_back('{1'b1, 9'd7,  1'b0, 1'b0, 1'b0, 1'b1, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd7,  1'b1, 1'b1, 1'b1, 1'b1, 9'd10, 1'b1});
        vecs.push_back('{1'b0, 9'd7,  1'b0, 1'b0, 1'b0, 1'b1, 9'd10, 1'b0});
        vecs.push_back('{1'b1, 9'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd0,  1'b0, 1'b1, 1'b1, 1'b1, 9'd10, 1'b1});
        vecs.push_back('{1'b0, 9'd0,  1'b0, 1'b0, 1'b0, 1'b1, 9'd10, 1'b0});
        // Test 3: ratio equal to current is a no-op ack after two cycles
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd10, 1'b1});
        vecs.push_back('{1'b1, 9'd10, 1'b0, 1'b1, 1'b0, 1'b1, 9'd10, 1'b1});
        vecs.push_back('{1'b0, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 9'd10, 1'b0});

        rstn_out = 1'b0;
        applyStimulus(1'b0, 9'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset_div_n", int'(div_n_o), 4);
        checkOutput("reset_gate", int'(clk_gate_en), 1);
        checkOutput("reset_ack", int'(cfg_ack), 0);
        checkOutput("reset_err", int'(cfg_err), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_timeout", int'(timeout_flag), 0);
        rstn_out = 1'b1;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].divIn, vecs[i].pe);
            tick();
            checkOutput($sformatf("vec%0d_ack", i), int'(cfg_ack), int'(vecs[i].ack));
            checkOutput($sformatf("vec%0d_err", i), int'(cfg_err), int'(vecs[i].err));
            checkOutput($sformatf("vec%0d_gate", i), int'(clk_gate_en), int'(vecs[i].gate));
            checkOutput($sformatf("vec%0d_div_n", i), int'(div_n_o), int'(vecs[i].divOut));
            checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].busy));
            checkOutput($sformatf("vec%0d_timeout", i), int'(timeout_flag), 0);
        end

        // Test 4: no period end, forced apply after the full timeout window
        applyStimulus(1'b1, 9'd12, 1'b0);
        tick();
        tick();
        n = 0;
        while (clk_gate_en && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("timeout_gate_delay", n, 1023);
        checkOutput("timeout_flag_set", int'(timeout_flag), 1);
        waitAck(20, n);
        checkOutput("timeout_ack_latency", n, 7);
        checkOutput("timeout_div_n", int'(div_n_o), 12);
        checkOutput("timeout_err", int'(cfg_err), 0);
        applyStimulus(1'b0, 9'd12, 1'b0);
        tick();
        checkOutput("timeout_flag_sticky", int'(timeout_flag), 1);
        applyStimulus(1'b1, 9'd12, 1'b0);
        tick();
        checkOutput("timeout_flag_cleared", int'(timeout_flag), 0);
        tick();
        applyStimulus(1'b0, 9'd12, 1'b0);
        tick();

        // Test 5: reset while gated in SETTLE
        applyStimulus(1'b1, 9'd8, 1'b0);
        tick();
        tick();
        div_period_end = 1'b1;
        tick();
        div_period_end = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("settle_gate_low", int'(clk_gate_en), 0);
        checkOutput("settle_div_n", int'(div_n_o), 8);
        rstn_out = 1'b0;
        #1;
        checkOutput("midreset_div_n", int'(div_n_o), 4);
        checkOutput("midreset_gate", int'(clk_gate_en), 1);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_ack", int'(cfg_ack), 0);
        applyStimulus(1'b0, 9'd8, 1'b0);
        tick();
        rstn_out = 1'b1;
        tick();
        applyStimulus(1'b1, 9'd2, 1'b0);
        tick();
        tick();
        div_period_end = 1'b1;
        tick();
        div_period_end = 1'b0;
        waitAck(20, n);
        checkOutput("postreset_div_n", int'(div_n_o), 2);
        checkOutput("postreset_err", int'(cfg_err), 0);
        applyStimulus(1'b0, 9'd2, 1'b0);
        tick();
        checkOutput("postreset_ack_drop", int'(cfg_ack), 0);

        // Test 6: shadow ignores cfg_div_n changes; held request does not retrigger
        applyStimulus(1'b1, 9'd10, 1'b1);
        tick();
        tick();
        checkOutput("pe_in_check_ignored", int'(clk_gate_en), 1);
        applyStimulus(1'b1, 9'd12, 1'b0);
        tick();
        checkOutput("wait_end_gate_high", int'(clk_gate_en), 1);
        div_period_end = 1'b1;
        tick();
        div_period_end = 1'b0;
        waitAck(20, n);
        checkOutput("shadow_div_n", int'(div_n_o), 10);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("held_ack", int'(cfg_ack), 1);
        checkOutput("held_busy", int'(busy), 1);
        applyStimulus(1'b0, 9'd12, 1'b0);
        tick();
        checkOutput("held_ack_drop", int'(cfg_ack), 0);
        checkOutput("held_idle", int'(busy), 0);
        tick();
        checkOutput("no_retrigger", int'(busy), 0);
        checkOutput("final_div_n", int'(div_n_o), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/clkdiv_cfg_sequencer.md
Name: clkdiv_cfg_sequencer

Overview:
Sequences run-time changes of the 9-bit even-divide ratio DIV_N feeding the configurable even clock divider. A requester proposes a new ratio over a 4-phase req/ack handshake. The block validates the ratio and waits for the end of a divided-clock period. It then gates the divided clock, applies the ratio, lets the divider counter settle, and ungates the clock. It sits beside the divider in the same clock/reset domain and owns the divider's DIV_N input and the output clock-gate enable.

Parameters:
DEFAULT_DIV_N, 9'd4, ratio driven on div_n_o after reset; must be even and >= 2.
GATE_CYC, 2, cycles to wait after deasserting clk_gate_en before applying the ratio (covers gate latency); 1..15.
SETTLE_CYC, 4, cycles after apply before re-enabling the gate; 1..15.
TIMEOUT_CYC, 1023, maximum cycles to wait for div_period_end before forcing the apply; 1..1023.

Ports:
clk_in_pre  input  1  divider source clock (post DFT clock mux)
rstn_out  input  1  reset, asynchronous, active-low
cfg_req  input  1  4-phase request; level held until cfg_ack seen
cfg_div_n  input  9  proposed ratio; stable while cfg_req high
cfg_ack  output  1  4-phase acknowledge
cfg_err  output  1  result flag, valid while cfg_ack high; 1 = ratio rejected
div_period_end  input  1  one-cycle pulse from divider: cnt == DIV_N/2-1 while divided clock high (last input cycle of an output period)
div_n_o  output  9  ratio driven to divider DIV_N
clk_gate_en  output  1  enable for divided-clock gate; 1 = clock passes
busy  output  1  high in any state other than IDLE
timeout_flag  output  1  sticky; set when an apply was forced by timeout; cleared on the next accepted request

Behaviour:
Reset values: div_n_o=DEFAULT_DIV_N, clk_gate_en=1, cfg_ack=0, cfg_err=0, busy=0, timeout_flag=0, state=IDLE, counters=0.
All outputs are registered. Reset mid-operation returns to IDLE with the above values; any in-flight request is dropped.

FSM states: IDLE, CHECK, WAIT_END, GATE, APPLY, SETTLE, ACK.

IDLE: on cfg_req=1, capture cfg_div_n into a shadow register, clear timeout_flag, and go to CHECK.

CHECK (1 cycle):
- Reject if the shadow ratio is odd or < 2 → ACK with cfg_err=1; div_n_o and the gate are untouched.
- If the shadow ratio equals div_n_o → ACK with cfg_err=0 (no-op, no gating).
- Otherwise clear the timeout counter and go to WAIT_END.

WAIT_END: count cycles.
- If div_period_end=1 → go to GATE.
- Else if count reaches TIMEOUT_CYC-1 → set timeout_flag and go to GATE.
- div_period_end takes priority when both occur in the same cycle.

GATE: clk_gate_en=0 from the first GATE cycle. Wait GATE_CYC cycles, then go to APPLY.

APPLY (1 cycle): div_n_o <= shadow. Go to SETTLE.
- The divider counter self-recovers: if cnt already exceeds the new DIV_N/2-1, it clears on the next edge.

SETTLE: wait SETTLE_CYC cycles. Then set clk_gate_en=1 and go to ACK.

ACK: cfg_ack=1, cfg_err as decided in CHECK.
- Hold until cfg_req=0, then drop cfg_ack/cfg_err the next cycle and go to IDLE.
- A new request is accepted only from IDLE; cfg_req staying high after ack does not retrigger.

Other rules:
- Latency from cfg_req rise to cfg_ack for a valid change: 1 (IDLE) + 1 (CHECK) + wait_end + GATE_CYC + 1 + SETTLE_CYC cycles.
- cfg_div_n changes while busy are ignored; only the shadow register is used.
- div_period_end outside WAIT_END is ignored.
- clk_gate_en is never low outside GATE/APPLY/SETTLE.

Test Plan:
1. After reset, check div_n_o=4, clk_gate_en=1, cfg_ack=0. Request cfg_div_n=10 with div_period_end pulsed 3 cycles after CHECK → gate low for exactly 2+1+4 cycles, div_n_o=10 in APPLY, cfg_ack=1 with cfg_err=0; cfg_ack drops one cycle after cfg_req falls.
2. Request cfg_div_n=7, then cfg_div_n=0 → each acks with cfg_err=1, div_n_o stays 4, clk_gate_en never drops.
3. Request cfg_div_n=4 (equal to current) → ack 2 cycles after cfg_req, cfg_err=0, no gating.
4. Hold div_period_end=0 with TIMEOUT_CYC=1023 → gating starts after 1023 WAIT_END cycles, timeout_flag=1 until the next accepted request.
5. Assert rstn_out low during SETTLE with clk_gate_en=0 → all outputs return to reset values immediately, div_n_o=DEFAULT_DIV_N; the next request completes normally.
6. Change cfg_div_n from 10 to 12 mid-WAIT_END and keep cfg_req high after ack → div_n_o=10, a single ack, no second transaction until cfg_req returns low and rises again.
